// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_out_reg.sv
// Single-entry IF output register: holds one fetched instruction until decode takes it.
module if_out_reg
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        consume_i,
  input  logic        kill_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Kill beats load; a load alone or with a consume replaces the entry.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (kill_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, runs the imem req/ack handshake
// and picks the next PC (recovery > prediction > sequential).
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             mispredict,
  input  logic [31:0]      recover_pc,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             flush,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      addr_q, addr_d;
  logic             req_q, req_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load, consume;

  assign load    = (state_q == REQ) && imem_ack && !mispredict;
  assign consume = if_valid && pc_write;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          state_d = REQ;
          if (!mispredict) begin
            pc_d    = pred_taken ? word_align(pred_target) : pc_q + 32'(INST_BYTES);
            state_d = (pc_write || !if_valid) ? REQ : HOLD;
          end
        end else if (mispredict) begin
          state_d = DROP;
        end
      end
      HOLD: if (pc_write || mispredict) state_d = REQ;
      // A response that completes the squashed request frees the bus even under a new mispredict.
      DROP: if (imem_ack) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (mispredict) pc_d = word_align(recover_pc);

    // The address only moves when a new request starts, so it is stable until ack.
    req_d          = (state_d == REQ) || (state_d == DROP);
    addr_d         = (state_d == REQ) ? pc_d : addr_q;
    flush_d        = mispredict;
    redirect_cnt_d = redirect_cnt_q + CNT_W'(mispredict);
    stall_cnt_d    = stall_cnt_q + CNT_W'(if_valid && !pc_write);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      addr_q         <= RESET_PC;
      req_q          <= 1'b0;
      flush_q        <= 1'b0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      addr_q         <= addr_d;
      req_q          <= req_d;
      flush_q        <= flush_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  if_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .consume_i (consume),
    .kill_i    (mispredict),
    .pc_i      (pc_q),
    .inst_i    (imem_rdata),
    .valid_o   (if_valid),
    .pc_o      (if_pc),
    .inst_o    (if_inst)
  );

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign flush        = flush_q;
  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed scenarios followed by random traffic.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b0, mispredict = 1'b0, pred_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] recover_pc = '0, pred_target = '0, imem_rdata = '0;
  logic        imem_req, if_valid, flush;
  logic [31:0] imem_addr, if_pc, if_inst;
  logic [15:0] redirect_cnt, stall_cnt;

  if_fetch_ctrl #(.RESET_PC(RESET_PC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .mispredict(mispredict),
    .recover_pc(recover_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .flush(flush), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  int          n_chk = 0, n_err = 0, n_consumed = 0;
  ent_t        exp_q[$];
  logic [31:0] m_next, m_cur, slow_addr;
  logic [15:0] n_redir;
  bit          sq, mem_busy, mon_en;
  int          mem_wait, lat_fix, slow_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus plus memory responder; expectations are pushed before the edge.
  task automatic cyc(input bit pw, input bit mp, input logic [31:0] rpc,
                     input bit pt, input logic [31:0] tgt);
    bit          ak;
    logic [31:0] rd;
    rd = $urandom;
    ak = 1'b0;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        m_cur    = m_next;
        if (m_cur == slow_addr) mem_wait = slow_lat;
        else if (lat_fix >= 0)  mem_wait = lat_fix;
        else                    mem_wait = int'($urandom_range(0, 3));
      end
      if (mem_wait == 0) begin
        ak       = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    if (mp) begin
      exp_q.delete();
      m_next = rpc & 32'hFFFF_FFFC;
      n_redir++;
      if (ak) sq = 1'b0;
      else if (imem_req) sq = 1'b1;
    end else if (ak) begin
      if (!sq) begin
        if (exp_q.size() != 0 && !pw) exp_q.delete();
        exp_q.push_back('{pc: m_cur, inst: rd});
        m_next = pt ? (tgt & 32'hFFFF_FFFC) : m_cur + 32'd4;
      end
      sq = 1'b0;
    end
    pc_write    = pw;
    mispredict  = mp;
    recover_pc  = rpc;
    pred_taken  = pt;
    pred_target = tgt;
    imem_ack    = ak;
    imem_rdata  = rd;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    pc_write   = 1'b0;
    mispredict = 1'b0;
    imem_ack   = 1'b0;
    pred_taken = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect_cnt", 32'(redirect_cnt), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_next   = RESET_PC;
    m_cur    = RESET_PC;
    sq       = 1'b0;
    mem_busy = 1'b0;
    mem_wait = 0;
    n_redir  = '0;
    mon_en   = 1'b1;
  endtask

  // Monitor: compares every post-edge DUT output against the scoreboard.
  initial begin
    bit          en_s, pw_s, mp_s, ak_s, had, req_prev;
    logic [31:0] addr_prev;
    logic [15:0] n_stall;
    had = 1'b0; req_prev = 1'b0; addr_prev = '0; n_stall = '0;
    forever begin
      @(posedge clk);
      en_s = mon_en; pw_s = pc_write; mp_s = mispredict; ak_s = imem_ack;
      @(negedge clk);
      if (!en_s) begin
        had = 1'b0; req_prev = 1'b0; n_stall = '0;
      end else begin
        if (had && !pw_s) n_stall++;
        if (had && pw_s && !mp_s && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end
        chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        if (if_valid && exp_q.size() != 0) begin
          chk("if_pc", if_pc, exp_q[0].pc);
          chk("if_inst", if_inst, exp_q[0].inst);
        end
        chk("flush", 32'(flush), 32'(mp_s));
        chk("redirect_cnt", 32'(redirect_cnt), 32'(n_redir));
        chk("stall_cnt", 32'(stall_cnt), 32'(n_stall));
        if (req_prev && !ak_s) begin
          chk("req_stable", 32'(imem_req), 32'd1);
          chk("addr_stable", imem_addr, addr_prev);
        end else if (imem_req) begin
          chk("req_addr", imem_addr, m_next);
        end
        had       = (exp_q.size() != 0);
        req_prev  = imem_req;
        addr_prev = imem_addr;
      end
    end
  end

  initial begin
    lat_fix = 0; slow_addr = 32'hFFFF_FFFF; slow_lat = 0;
    do_reset();

    // Zero-wait streaming
    repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stream_addr", imem_addr, 32'h14);
    chk("stream_pc", if_pc, 32'h10);

    // Two-cycle latency with a taken prediction on PC 0x8
    do_reset(); lat_fix = 2;
    repeat (16) cyc(1'b1, 1'b0, 32'h0, m_cur == 32'h8, 32'h100);
    chk("pred_if_pc", if_pc, 32'h104);

    // Decode stall into HOLD, then release
    do_reset(); lat_fix = 0;
    repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_pc", if_pc, 32'h4);
    chk("hold_stall", 32'(stall_cnt), 32'd3);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("release_req", 32'(imem_req), 32'd1);
    chk("release_addr", imem_addr, 32'h8);
    repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Mispredict while 0x10 awaits its ack
    do_reset(); slow_addr = 32'h10; slow_lat = 3;
    for (int i = 0; i < 40 && !(m_cur == 32'h10 && mem_busy); i++)
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h203, 1'b0, 32'h0);
    chk("mp_flush", 32'(flush), 32'd1);
    chk("mp_addr_hold", imem_addr, 32'h10);
    repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("drop_valid", 32'(if_valid), 32'd0);
    chk("drop_next_addr", imem_addr, 32'h200);
    chk("drop_redirect", 32'(redirect_cnt), 32'd1);
    slow_addr = 32'hFFFF_FFFF;
    repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Mispredict coinciding with ack and a taken prediction
    do_reset(); lat_fix = 1;
    for (int i = 0; i < 40 && !(imem_req && mem_busy && mem_wait == 0); i++)
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h400, 1'b1, 32'h800);
    chk("mpack_valid", 32'(if_valid), 32'd0);
    chk("mpack_addr", imem_addr, 32'h400);
    repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Asynchronous reset while a squashed request is still owed
    do_reset(); lat_fix = 0; slow_addr = 32'h8; slow_lat = 6;
    for (int i = 0; i < 40 && !(m_cur == 32'h8 && mem_busy); i++)
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("drop_req_before_rst", 32'(imem_req), 32'd1);
    do_reset(); slow_addr = 32'hFFFF_FFFF;
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Random traffic
    do_reset(); lat_fix = -1;
    repeat (3000) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom,
          $urandom_range(0, 2) == 0, $urandom & 32'hFFFF_FFFC);
    end
    chk("progress", 32'(n_consumed > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch sequencer in front of the instruction memory and branch predictor of the IF stage.
- Owns the architectural fetch PC and issues one instruction-memory request at a time over a req/ack handshake.
- Selects the next PC by priority: EX/MEM misprediction recovery, then predictor redirect, then PC+4.
- Holds the fetched instruction in a single-entry output register while decode stalls (pc_write low).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- CNT_W, 16, width of the redirect and stall performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- pc_write  in  1  decode ready; output register is consumed when if_valid and pc_write are both 1.
- mispredict  in  1  recovery request from EX/MEM; highest priority.
- recover_pc  in  32  correct PC on mispredict.
- pred_taken  in  1  predictor taken decision for the instruction on imem_rdata; sampled only in the ack cycle.
- pred_target  in  32  predicted target; sampled with pred_taken.
- imem_req  out  1  memory request valid.
- imem_addr  out  32  request address; word aligned, stable while imem_req=1.
- imem_ack  in  1  response valid; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  output register holds an instruction.
- if_pc  out  32  PC of the held instruction.
- if_inst  out  32  held instruction.
- flush  out  1  one-cycle pulse; downstream kills its IF/ID entry.
- redirect_cnt  out  CNT_W  count of mispredict events; wraps.
- stall_cnt  out  CNT_W  count of cycles with if_valid=1 and pc_write=0; wraps.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, pc_q=RESET_PC.
  - imem_req=0, if_valid=0, if_pc=0, if_inst=0, flush=0, both counters=0.
- States:
  - IDLE: imem_req=0. Next cycle -> REQ.
  - REQ: imem_req=1, imem_addr=pc_q.
  - HOLD: output register full and not consumed; imem_req=0.
  - DROP: a response is still owed for a squashed request; imem_req=1, imem_addr=old address.
- REQ, ack with no mispredict:
  - Load if_inst=imem_rdata, if_pc=pc_q, if_valid=1 on the next edge.
  - pc_q <= pred_taken ? pred_target : pc_q+4 (32-bit, wraps modulo 2^32).
  - Next state is REQ if pc_write=1 or if_valid=0 this cycle, else HOLD.
  - Back-to-back: a zero-wait ack gives one instruction per cycle.
- REQ without ack: hold the address; no new request may be issued.
- Output register consumption:
  - A consume (if_valid & pc_write) without a simultaneous load clears if_valid.
  - A load and a consume in the same cycle replace the entry.
- HOLD: on pc_write=1 clear if_valid and go to REQ. The next request issues in the following cycle.
- Mispredict (overrides everything in the same cycle):
  - pc_q <= {recover_pc[31:2],2'b00}; if_valid <= 0; flush=1 for exactly one cycle; redirect_cnt += 1.
  - In REQ without ack -> DROP.
  - In REQ with ack -> discard imem_rdata and go to REQ; the next request uses the recovery PC.
  - In IDLE/HOLD -> REQ.
  - In DROP -> stay DROP; pc_q takes the newest recover_pc.
- DROP: on ack, discard the data (if_valid stays 0) and go to REQ.
- pred_taken/pred_target outside an accepted ack cycle: ignored.
- The handshake is never abandoned: once imem_req=1, it and imem_addr stay stable until ack.
- Counters increment in the cycle after the event (registered).

Decomposition:
- Shared package if_pkg holds:
  - fetch_state_e {IDLE, REQ, HOLD, DROP} (2-bit enum).
  - INST_BYTES=4.
  - NOP_INST=32'h0000_0013.
- One sub-module, if_out_reg: the single-entry valid/pc/inst holding register with load, consume and kill inputs.
- The FSM, next-PC priority mux and counters stay in if_fetch_ctrl.

Test Plan:
- Reset then zero-wait ack, pc_write=1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; if_valid=1 from cycle 2; if_pc trails imem_addr by one cycle.
- 2-cycle ack latency, pred_taken=1, pred_target=0x100 in the ack cycle for PC 0x8 -> next imem_addr=0x100; imem_addr stable at 0x8 until ack.
- pc_write=0 for 3 cycles after a fetch of 0x4 -> HOLD; imem_req=0; if_pc=0x4 held; stall_cnt=3. Release -> request 0x8 next cycle.
- Mispredict with recover_pc=0x203 while REQ 0x10 awaits ack -> flush one cycle; state DROP. Ack 2 cycles later is discarded (if_valid=0). Next imem_addr=0x200; redirect_cnt=1.
- Mispredict in the same cycle as ack and pred_taken=1 -> data and prediction discarded; next imem_addr=recover_pc; no if_valid for the squashed instruction.
- Assert rst in DROP with imem_req=1 -> all outputs reset immediately (asynchronous). After release, the first imem_addr=RESET_PC.
